// File: rtl/mem_boot_arbiter_pkg.sv
// Shared types and default constants for the boot/game loader arbiter.
// The program base is also used by the CPU to reset its PC.
package mem_boot_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        WRITE,
        DONE
    } state_t;

    localparam logic [11:0] PROGRAM_BASE   = 12'h200;
    localparam int          RAM_AW_DEF     = 14;
    localparam logic [15:0] LOAD_BASE_DEF  = {4'h0, PROGRAM_BASE};
    localparam int          LOAD_LEN_DEF   = 3584;
    localparam int          BANK_SHIFT_DEF = 12;
    localparam int          IDX_W          = 12;

endpackage

// File: rtl/mem_boot_arbiter_mem_port_mux.sv
// Combinational owner select for the ROM read port and RAM write port:
// the loader drives them while busy, otherwise the CPU passes straight through.
module mem_boot_arbiter_mem_port_mux #(
    parameter int RAM_AW = 14
) (
    input  logic              sel_loader_i,
    input  logic [15:0]       cpu_rom_addr_i,
    input  logic [RAM_AW-1:0] cpu_ram_addr_i,
    input  logic [7:0]        cpu_ram_din_i,
    input  logic              cpu_ram_we_i,
    input  logic [15:0]       ld_rom_addr_i,
    input  logic [RAM_AW-1:0] ld_ram_addr_i,
    input  logic [7:0]        ld_ram_din_i,
    input  logic              ld_ram_we_i,
    input  logic              rom_dready_i,
    output logic [15:0]       rom_addr_o,
    output logic              cpu_rom_dready_o,
    output logic [RAM_AW-1:0] ram_addr_o,
    output logic [7:0]        ram_din_o,
    output logic              ram_we_o
);

    always_comb begin
        rom_addr_o       = cpu_rom_addr_i;
        cpu_rom_dready_o = rom_dready_i;
        ram_addr_o       = cpu_ram_addr_i;
        ram_din_o        = cpu_ram_din_i;
        ram_we_o         = cpu_ram_we_i;
        if (sel_loader_i) begin
            rom_addr_o       = ld_rom_addr_i;
            cpu_rom_dready_o = 1'b0;
            ram_addr_o       = ld_ram_addr_i;
            ram_din_o        = ld_ram_din_i;
            ram_we_o         = ld_ram_we_i;
        end
    end

endmodule

// File: rtl/mem_boot_arbiter.sv
// Boot/game loader: holds the CPU, copies one ROM bank into RAM at the
// program base, then releases the CPU with a one-cycle start pulse.
module mem_boot_arbiter
    import mem_boot_arbiter_pkg::*;
#(
    parameter int          RAM_AW     = RAM_AW_DEF,
    parameter logic [15:0] LOAD_BASE  = LOAD_BASE_DEF,
    parameter int          LOAD_LEN   = LOAD_LEN_DEF,
    parameter int          BANK_SHIFT = BANK_SHIFT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req,
    input  logic [3:0]        game_sel,
    output logic              busy,
    output logic              cpu_hold,
    output logic              cpu_start,
    input  logic [15:0]       cpu_rom_addr,
    output logic              cpu_rom_dready,
    input  logic [15:0]       cpu_ram_addr,
    input  logic [7:0]        cpu_ram_din,
    input  logic              cpu_ram_we,
    output logic [15:0]       rom_addr,
    input  logic [7:0]        rom_dout,
    input  logic              rom_dready,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [7:0]        ram_din,
    output logic              ram_we
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LOAD_LEN - 1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [3:0]        bank_q, bank_d;
    logic [7:0]        data_q, data_d;
    logic              started_q, started_d;

    logic [15:0]       ldRomAddr;
    logic [RAM_AW-1:0] ldRamAddr;
    logic [7:0]        ldRamDin;
    logic              ldRamWe;
    logic              unused_cpu_addr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= FETCH;
            idx_q     <= '0;
            bank_q    <= '0;
            data_q    <= '0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            bank_q    <= bank_d;
            data_q    <= data_d;
            started_q <= started_d;
        end
    end

    // Coming out of reset the FSM sits in FETCH for one extra edge to sample
    // game_sel; only then does the first real fetch address go out.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        bank_d    = bank_q;
        data_d    = data_q;
        started_d = started_q;
        case (state_q)
            IDLE: begin
                if (load_req) begin
                    bank_d  = game_sel;
                    idx_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (!started_q) begin
                    bank_d    = game_sel;
                    started_d = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (rom_dready) begin
                    data_d  = rom_dout;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = FETCH;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q != IDLE) && (state_q != DONE);
    assign cpu_hold  = busy;
    assign cpu_start = (state_q == DONE);

    // Loader-side port values; RAM signals stay zero outside the WRITE cycle.
    assign ldRomAddr = (16'(bank_q) << BANK_SHIFT) + 16'(idx_q);
    assign ldRamWe   = (state_q == WRITE);
    assign ldRamAddr = ldRamWe ? RAM_AW'(LOAD_BASE + 16'(idx_q)) : '0;
    assign ldRamDin  = ldRamWe ? data_q : 8'h00;

    assign unused_cpu_addr = ^cpu_ram_addr;

    mem_boot_arbiter_mem_port_mux #(
        .RAM_AW(RAM_AW)
    ) u_mux (
        .sel_loader_i     (busy),
        .cpu_rom_addr_i   (cpu_rom_addr),
        .cpu_ram_addr_i   (cpu_ram_addr[RAM_AW-1:0]),
        .cpu_ram_din_i    (cpu_ram_din),
        .cpu_ram_we_i     (cpu_ram_we),
        .ld_rom_addr_i    (ldRomAddr),
        .ld_ram_addr_i    (ldRamAddr),
        .ld_ram_din_i     (ldRamDin),
        .ld_ram_we_i      (ldRamWe),
        .rom_dready_i     (rom_dready),
        .rom_addr_o       (rom_addr),
        .cpu_rom_dready_o (cpu_rom_dready),
        .ram_addr_o       (ram_addr),
        .ram_din_o        (ram_din),
        .ram_we_o         (ram_we)
    );

endmodule

// File: doc/mem_boot_arbiter.md
Name: mem_boot_arbiter

Overview:
- Owns the single ROM read port and the single RAM write port between two requesters: an internal boot/game loader and the CPU.
- After reset, or on a game-select request, it holds the CPU and copies the selected game image from ROM into RAM at the program base. It then releases the CPU with a start pulse.
- Sits between the cpu, rom and ram instances in the top level.

Parameters:
- RAM_AW, 14, RAM address width; ram_addr is truncated to this width.
- LOAD_BASE, 16'h0200, RAM destination of byte 0 of the image.
- LOAD_LEN, 3584, bytes copied per load (0x200..0xFFF).
- BANK_SHIFT, 12, ROM byte offset of game n is n << BANK_SHIFT.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- load_req  in  1  one-cycle request to (re)load a game.
- game_sel  in  4  game index; sampled on an accepted load_req and on reset release.
- busy  out  1  loader owns the ROM/RAM ports.
- cpu_hold  out  1  CPU must stall; equals busy.
- cpu_start  out  1  one-cycle pulse when a load completes; CPU resets PC.
- cpu_rom_addr  in  16  CPU ROM read address.
- cpu_rom_dready  out  1  rom_dready forwarded; forced 0 while busy.
- cpu_ram_addr  in  16  CPU RAM address.
- cpu_ram_din  in  8  CPU RAM write data.
- cpu_ram_we  in  1  CPU RAM write enable.
- rom_addr  out  16  to rom.
- rom_dout  in  8  from rom.
- rom_dready  in  1  from rom; data valid for the current rom_addr.
- ram_addr  out  RAM_AW  to ram.
- ram_din  out  8  to ram.
- ram_we  out  1  to ram.

Behaviour:
- Reset values (reset=0):
  - State is FETCH, idx=0, bank=0.
  - busy=1, cpu_hold=1, cpu_start=0.
  - rom_addr=0, ram_addr=0, ram_din=0, ram_we=0, cpu_rom_dready=0.
- On reset release, bank is latched from game_sel on the first clock edge, and loading begins.
- State machine:
  - IDLE: not busy.
    - rom_addr=cpu_rom_addr, cpu_rom_dready=rom_dready.
    - ram_addr=cpu_ram_addr[RAM_AW-1:0], ram_din=cpu_ram_din, ram_we=cpu_ram_we.
    - These pass through combinationally, with zero added latency.
    - On load_req: latch bank=game_sel, idx=0, go to FETCH.
  - FETCH: rom_addr=(bank<<BANK_SHIFT)+idx, registered. Next state is WAIT.
  - WAIT: rom_addr held. When rom_dready=1, capture rom_dout into a data register and go to WRITE. Otherwise stay in WAIT, with no timeout.
  - WRITE: ram_addr=LOAD_BASE+idx, ram_din=data register, ram_we=1 for exactly this cycle.
    - If idx==LOAD_LEN-1, go to DONE.
    - Otherwise idx+1, go to FETCH.
  - DONE: cpu_start=1 for one cycle, busy drops to 0 in the same cycle, next state is IDLE.
- While busy:
  - All CPU port inputs are ignored, and CPU writes are dropped (the CPU is held).
  - load_req is ignored.
- Simultaneous load_req in the DONE cycle: ignored.
- Throughput: minimum 3 cycles per byte (FETCH, WAIT with dready=1, WRITE). A full load with zero ROM wait states is 3*LOAD_LEN+1 cycles from FETCH entry to the cpu_start pulse.
- Width rules:
  - idx is 12 bits; wrap is impossible because LOAD_LEN <= 4096.
  - ROM address sum is 16-bit modulo.
  - RAM address is truncated to RAM_AW.
- Reset asserted mid-load: immediate abort to reset values. After release, reload restarts from idx 0, with game_sel re-sampled.
- rom_dready from a prior CPU access that is still high on entry to WAIT is not trusted. The WAIT state samples rom_dready only from the cycle after FETCH.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, FETCH, WAIT, WRITE, DONE);
  - LOAD_BASE, LOAD_LEN, BANK_SHIFT defaults;
  - the CHIP-8 program-base constant 12'h200, shared with cpu.
- Optional sub-module mem_port_mux: the purely combinational IDLE/loader select for the rom/ram signals. The FSM stays in the parent.

Test Plan:
- Reset release with game_sel=3, ROM model with dready one cycle after each address change, and LOAD_LEN=4:
  - ROM reads 0x3000..0x3003.
  - RAM writes to 0x200..0x203 with matching data.
  - One cpu_start pulse after the last write, then busy=0.
- IDLE passthrough: cpu_ram_addr=0x0ABC, din=0x5A, we=1 -> same-cycle ram_addr=0x0ABC, ram_din=0x5A, ram_we=1. cpu_rom_addr=0x0123 -> rom_addr=0x0123.
- ROM wait states (dready held low for 5 cycles on byte 2):
  - FSM stays in WAIT with rom_addr stable.
  - No ram_we pulse until dready.
  - Written data is the value present on rom_dout when dready rises.
- load_req pulse during a load, and CPU writes during a load -> no effect on bank. No RAM writes from the CPU address/data. cpu_rom_dready=0 throughout.
- Reset asserted mid-load at idx=2 (LOAD_LEN=4):
  - Outputs go to reset values asynchronously.
  - After release, the copy restarts at idx 0 with the new game_sel.
- Back-to-back load_req in IDLE, game_sel=1 then 2:
  - Second load copies from 0x2000.
  - Exactly one cpu_start per completed load.
